// File: rtl/seg_display_scan.sv
// seg_display_scan: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. A hex value is captured on a load strobe and
// committed to the scanned frame only at frame wrap, so digits never tear.
// All display pins (seg, dp, an) are active-low.
module seg_display_scan #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    input  logic        load,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [19:0]   pend;
    logic          pend_v;
    logic [19:0]   shown;

    logic          tick;
    logic          wrap;

    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    dec_seg;
    logic [3:0]    dec_an;
    logic          dec_dp;

    // Hex font, segments {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'h40;
            4'h1: font = 7'h79;
            4'h2: font = 7'h24;
            4'h3: font = 7'h30;
            4'h4: font = 7'h19;
            4'h5: font = 7'h12;
            4'h6: font = 7'h02;
            4'h7: font = 7'h78;
            4'h8: font = 7'h00;
            4'h9: font = 7'h10;
            4'hA: font = 7'h08;
            4'hB: font = 7'h03;
            4'hC: font = 7'h46;
            4'hD: font = 7'h21;
            4'hE: font = 7'h06;
            default: font = 7'h0E;
        endcase
    endfunction

    assign tick = (cnt == CNT_MAX);
    assign wrap = tick && (idx == 2'd3);

    // Prescaler, digit index, pending/committed frame registers and wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            pend       <= 20'd0;
            pend_v     <= 1'b0;
            shown      <= 20'd0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + 1'b1;
            frame_done <= wrap;
            if (tick)
                idx <= idx + 2'd1;
            if (wrap) begin
                // A load coinciding with the wrap bypasses pend and goes
                // straight into the new frame; anything pending is dropped.
                if (load)
                    shown <= {dp_in, value};
                else if (pend_v)
                    shown <= pend;
                pend_v <= 1'b0;
            end else if (load) begin
                pend   <= {dp_in, value};
                pend_v <= 1'b1;
            end
        end
    end

    // Digit decode with leading-zero blanking; digit 0 always shows.
    always_comb begin
        nib   = shown[{idx, 2'b00} +: 4];
        blank = 1'b0;
        case (idx)
            2'd1:    blank = blank_lz && (shown[15:4]  == 12'd0);
            2'd2:    blank = blank_lz && (shown[15:8]  == 8'd0);
            2'd3:    blank = blank_lz && (shown[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
        if (blank) begin
            dec_an  = 4'b1111;
            dec_seg = 7'h7F;
            dec_dp  = 1'b1;
        end else begin
            dec_an  = ~(4'b0001 << idx);
            dec_seg = font(nib);
            dec_dp  = ~shown[16 + {30'd0, idx}];
        end
    end

    // Register the decoded digit onto the pins so they switch glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= dec_an;
            seg <= dec_seg;
            dp  <= dec_dp;
        end
    end

endmodule
